// File: rtl/pdp8_mem_pkg.sv
// Shared types and constants for the PDP-8 memory-port arbiter.
package pdp8_mem_pkg;

    localparam int unsigned WORD_W    = 12;
    localparam int unsigned TMO_CNT_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_BRK = 1'b1
    } port_t;

    // One latched memory transaction as presented by a requester.
    typedef struct packed {
        word_t address;
        word_t write_data;
        logic  write_enable;
    } mem_txn_t;

endpackage

// File: rtl/pdp8_mem_req_latch.sv
// Per-port request capture: holds one outstanding transaction and flags overruns.
module pdp8_mem_req_latch
    import pdp8_mem_pkg::*;
(
    input  logic     clk,
    input  logic     nrst,
    input  word_t    address,
    input  word_t    write_data,
    input  logic     write_enable,
    input  logic     mem_load,
    input  logic     done,
    output logic     pending,
    output mem_txn_t txn,
    output logic     overrun_c
);

    logic accept_c;

    // A strobe is taken when idle, or in the ready cycle that retires the current request.
    always_comb begin
        accept_c  = mem_load && (!pending || done);
        overrun_c = mem_load && pending && !done;
    end

    // Capture wins over retirement so a strobe in the ready cycle starts a new request.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pending <= 1'b0;
            txn     <= '0;
        end else if (accept_c) begin
            pending <= 1'b1;
            txn     <= '{address: address, write_data: write_data, write_enable: write_enable};
        end else if (done) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/pdp8_mem_arbiter.sv
// Serialises CPU and data-break transactions onto one req/ack memory port.
module pdp8_mem_arbiter
    import pdp8_mem_pkg::*;
#(
    parameter bit          BRK_PRIORITY = 1'b1,
    parameter int unsigned TIMEOUT      = 16,
    parameter word_t       TMO_DATA     = 12'o0000
) (
    input  logic  clk,
    input  logic  nrst,
    input  word_t cpu_address,
    input  word_t cpu_write_data,
    input  logic  cpu_write_enable,
    input  logic  cpu_mem_load,
    output word_t cpu_read_data,
    output logic  cpu_mem_ready,
    input  word_t brk_address,
    input  word_t brk_write_data,
    input  logic  brk_write_enable,
    input  logic  brk_mem_load,
    output word_t brk_read_data,
    output logic  brk_mem_ready,
    output word_t mem_address,
    output word_t mem_write_data,
    output logic  mem_write_enable,
    output logic  mem_req,
    input  word_t mem_read_data,
    input  logic  mem_ack,
    input  logic  clr_status,
    output logic  busy,
    output logic  grant_brk,
    output logic  overrun,
    output logic  timeout
);

    arb_state_t           state;
    logic [TMO_CNT_W-1:0] tmo_cnt;

    logic     cpu_pending;
    logic     brk_pending;
    logic     cpu_overrun_c;
    logic     brk_overrun_c;
    mem_txn_t cpu_txn;
    mem_txn_t brk_txn;

    port_t    grant_port_c;
    mem_txn_t grant_txn_c;
    logic     ack_c;
    logic     tmo_hit_c;
    logic     finish_c;
    word_t    resp_data_c;

    pdp8_mem_req_latch u_cpu_latch (
        .clk          (clk),
        .nrst         (nrst),
        .address      (cpu_address),
        .write_data   (cpu_write_data),
        .write_enable (cpu_write_enable),
        .mem_load     (cpu_mem_load),
        .done         (cpu_mem_ready),
        .pending      (cpu_pending),
        .txn          (cpu_txn),
        .overrun_c    (cpu_overrun_c)
    );

    pdp8_mem_req_latch u_brk_latch (
        .clk          (clk),
        .nrst         (nrst),
        .address      (brk_address),
        .write_data   (brk_write_data),
        .write_enable (brk_write_enable),
        .mem_load     (brk_mem_load),
        .done         (brk_mem_ready),
        .pending      (brk_pending),
        .txn          (brk_txn),
        .overrun_c    (brk_overrun_c)
    );

    // Grant choice, completion detection and the word returned to the owner.
    always_comb begin
        grant_port_c = PORT_CPU;
        // grant_brk doubles as the round-robin pointer (last owner).
        if (brk_pending && (!cpu_pending || BRK_PRIORITY || !grant_brk)) begin
            grant_port_c = PORT_BRK;
        end
        grant_txn_c = (grant_port_c == PORT_BRK) ? brk_txn : cpu_txn;

        ack_c     = (state == REQ) && mem_ack;
        tmo_hit_c = (state == REQ) && !mem_ack && (TIMEOUT != 0)
                    && (tmo_cnt == TMO_CNT_W'(TIMEOUT - 1));
        finish_c  = ack_c || tmo_hit_c;

        resp_data_c = TMO_DATA;
        if (ack_c) begin
            resp_data_c = mem_write_enable ? mem_write_data : mem_read_data;
        end
    end

    // Arbitration FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state            <= IDLE;
            tmo_cnt          <= '0;
            mem_req          <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            busy             <= 1'b0;
            grant_brk        <= 1'b0;
            cpu_read_data    <= '0;
            cpu_mem_ready    <= 1'b0;
            brk_read_data    <= '0;
            brk_mem_ready    <= 1'b0;
        end else begin
            cpu_mem_ready <= 1'b0;
            brk_mem_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_pending || brk_pending) begin
                        state            <= REQ;
                        mem_req          <= 1'b1;
                        busy             <= 1'b1;
                        tmo_cnt          <= '0;
                        grant_brk        <= (grant_port_c == PORT_BRK);
                        mem_address      <= grant_txn_c.address;
                        mem_write_data   <= grant_txn_c.write_data;
                        mem_write_enable <= grant_txn_c.write_enable;
                    end
                end
                REQ: begin
                    if (finish_c) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (grant_brk) begin
                            brk_read_data <= resp_data_c;
                            brk_mem_ready <= 1'b1;
                        end else begin
                            cpu_read_data <= resp_data_c;
                            cpu_mem_ready <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky status: a set in the same cycle beats clr_status.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (cpu_overrun_c || brk_overrun_c) begin
                overrun <= 1'b1;
            end else if (clr_status) begin
                overrun <= 1'b0;
            end
            if (tmo_hit_c) begin
                timeout <= 1'b1;
            end else if (clr_status) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Scoreboard bench for pdp8_mem_arbiter: fixed-priority/timeout instance plus a round-robin instance.
module tb_pdp8_mem_arbiter;
    import pdp8_mem_pkg::*;

    logic  clk = 1'b0;
    logic  nrst = 1'b0;
    word_t cpu_address = '0, cpu_write_data = '0, brk_address = '0, brk_write_data = '0;
    logic  cpu_write_enable = 1'b0, cpu_mem_load = 1'b0, brk_write_enable = 1'b0, brk_mem_load = 1'b0;
    logic  clr_status = 1'b0;
    word_t cpu_read_data, brk_read_data, mem_address, mem_write_data, mem_read_data;
    logic  cpu_mem_ready, brk_mem_ready, mem_write_enable, mem_req, mem_ack;
    logic  busy, grant_brk, overrun, timeout;

    logic  rr_cpu_load = 1'b0, rr_brk_load = 1'b0;
    word_t rr_cpu_read_data, rr_brk_read_data, rr_mem_address, rr_mem_write_data, rr_mem_read_data;
    logic  rr_cpu_mem_ready, rr_brk_mem_ready, rr_mem_write_enable, rr_mem_req, rr_mem_ack;
    logic  rr_busy, rr_grant_brk, rr_overrun, rr_timeout;

    int errors = 0;
    int checks = 0;

    mem_txn_t exp_mem[$];
    word_t    exp_cpu[$];
    word_t    exp_brk[$];
    word_t    exp_rr[$];
    mem_txn_t cur_mem = '0;
    logic     mem_prev = 1'b0, rr_prev = 1'b0, cpu_rdy_prev = 1'b0, brk_rdy_prev = 1'b0;
    int       rr_cpu_pulses = 0, rr_brk_pulses = 0;

    word_t mem_arr [4096];
    int    ws = 0;
    bit    no_ack = 1'b0;
    int    ws_cnt = 0;
    logic  model_ack = 1'b0;
    logic  stray_ack = 1'b0;
    word_t mem_rd = '0;
    int    req_cycles;

    always #5 clk = ~clk;

    pdp8_mem_arbiter #(.BRK_PRIORITY(1'b1), .TIMEOUT(8), .TMO_DATA(12'o5252)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
        .cpu_write_enable(cpu_write_enable), .cpu_mem_load(cpu_mem_load),
        .cpu_read_data(cpu_read_data), .cpu_mem_ready(cpu_mem_ready),
        .brk_address(brk_address), .brk_write_data(brk_write_data),
        .brk_write_enable(brk_write_enable), .brk_mem_load(brk_mem_load),
        .brk_read_data(brk_read_data), .brk_mem_ready(brk_mem_ready),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_req(mem_req),
        .mem_read_data(mem_read_data), .mem_ack(mem_ack),
        .clr_status(clr_status), .busy(busy), .grant_brk(grant_brk),
        .overrun(overrun), .timeout(timeout)
    );

    pdp8_mem_arbiter #(.BRK_PRIORITY(1'b0), .TIMEOUT(0)) dut_rr (
        .clk(clk), .nrst(nrst),
        .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
        .cpu_write_enable(cpu_write_enable), .cpu_mem_load(rr_cpu_load),
        .cpu_read_data(rr_cpu_read_data), .cpu_mem_ready(rr_cpu_mem_ready),
        .brk_address(brk_address), .brk_write_data(brk_write_data),
        .brk_write_enable(brk_write_enable), .brk_mem_load(rr_brk_load),
        .brk_read_data(rr_brk_read_data), .brk_mem_ready(rr_brk_mem_ready),
        .mem_address(rr_mem_address), .mem_write_data(rr_mem_write_data),
        .mem_write_enable(rr_mem_write_enable), .mem_req(rr_mem_req),
        .mem_read_data(rr_mem_read_data), .mem_ack(rr_mem_ack),
        .clr_status(clr_status), .busy(rr_busy), .grant_brk(rr_grant_brk),
        .overrun(rr_overrun), .timeout(rr_timeout)
    );

    // Round-robin instance memory: zero-wait ack, returns its own address for reads.
    assign rr_mem_ack       = rr_mem_req;
    assign rr_mem_read_data = rr_mem_address | rr_mem_write_data;

    // Main memory model with configurable wait states, optional no-ack and stray ack.
    assign mem_ack       = model_ack | stray_ack;
    assign mem_read_data = mem_rd;
    always @(negedge clk) begin : mem_model
        if (mem_req) begin
            if (!no_ack && ws_cnt >= ws) begin
                if (mem_write_enable) mem_arr[mem_address] = mem_write_data;
                mem_rd    = mem_arr[mem_address];
                model_ack = 1'b1;
            end else begin
                model_ack = 1'b0;
            end
            ws_cnt++;
        end else begin
            model_ack = 1'b0;
            ws_cnt    = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'o%0o, expected 'o%0o at %0t", name, act, exp, $time);
        end
    endtask

    // Memory-side monitor: each new request is matched against the expected queue, then held stable.
    always @(negedge clk) begin : mon_mem
        if (mem_req && !mem_prev) begin
            check("mem_req_expected", 32'(exp_mem.size() != 0), 1);
            if (exp_mem.size() != 0) begin
                cur_mem = exp_mem.pop_front();
                check("mem_address", 32'(mem_address), 32'(cur_mem.address));
                check("mem_write_enable", 32'(mem_write_enable), 32'(cur_mem.write_enable));
                if (cur_mem.write_enable) check("mem_write_data", 32'(mem_write_data), 32'(cur_mem.write_data));
            end
        end else if (mem_req) begin
            check("mem_address_stable", 32'(mem_address), 32'(cur_mem.address));
            check("mem_we_stable", 32'(mem_write_enable), 32'(cur_mem.write_enable));
            if (cur_mem.write_enable) check("mem_wdata_stable", 32'(mem_write_data), 32'(cur_mem.write_data));
        end
        mem_prev = mem_req;
    end

    // Response monitor for both requester ports of the main instance.
    always @(negedge clk) begin : mon_resp
        word_t e;
        if (cpu_mem_ready) begin
            check("cpu_ready_width", 32'(cpu_rdy_prev), 0);
            check("cpu_ready_expected", 32'(exp_cpu.size() != 0), 1);
            if (exp_cpu.size() != 0) begin
                e = exp_cpu.pop_front();
                check("cpu_read_data", 32'(cpu_read_data), 32'(e));
            end
        end
        if (brk_mem_ready) begin
            check("brk_ready_width", 32'(brk_rdy_prev), 0);
            check("brk_ready_expected", 32'(exp_brk.size() != 0), 1);
            if (exp_brk.size() != 0) begin
                e = exp_brk.pop_front();
                check("brk_read_data", 32'(brk_read_data), 32'(e));
            end
        end
        cpu_rdy_prev = cpu_mem_ready;
        brk_rdy_prev = brk_mem_ready;
    end

    // Round-robin instance monitor: grant order seen as the sequence of issued addresses.
    always @(negedge clk) begin : mon_rr
        word_t e;
        if (rr_mem_req && !rr_prev) begin
            check("rr_req_expected", 32'(exp_rr.size() != 0), 1);
            if (exp_rr.size() != 0) begin
                e = exp_rr.pop_front();
                check("rr_grant_order", 32'(rr_mem_address), 32'(e));
            end
            check("rr_mem_we", 32'(rr_mem_write_enable), 0);
        end
        if (rr_cpu_mem_ready) rr_cpu_pulses++;
        if (rr_brk_mem_ready) rr_brk_pulses++;
        rr_prev = rr_mem_req;
    end

    task automatic drive(input logic [3:0] ld, input word_t ca, input word_t cd, input logic cwe,
                         input word_t ba, input word_t bd, input logic bwe);
        cpu_address = ca; cpu_write_data = cd; cpu_write_enable = cwe;
        brk_address = ba; brk_write_data = bd; brk_write_enable = bwe;
        cpu_mem_load = ld[0]; brk_mem_load = ld[1]; rr_cpu_load = ld[2]; rr_brk_load = ld[3];
        @(posedge clk); #1;
        cpu_mem_load = 1'b0; brk_mem_load = 1'b0; rr_cpu_load = 1'b0; rr_brk_load = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr_status = 1'b1;
        @(negedge clk); clr_status = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stim
        for (int i = 0; i < 4096; i++) mem_arr[i] = '0;
        mem_arr[12'o0200] = 12'o1234;
        mem_arr[12'o0300] = 12'o4321;
        mem_arr[12'o0100] = 12'o0777;

        // Reset state
        cycles(2);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_brk", 32'(grant_brk), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_cpu_ready", 32'(cpu_mem_ready), 0);
        check("rst_cpu_rdata", 32'(cpu_read_data), 0);
        check("rst_mem_address", 32'(mem_address), 0);
        nrst = 1'b1;
        cycles(1);

        // 1: CPU read with first-cycle ack, latency checks
        exp_mem.push_back('{12'o0200, 12'o0000, 1'b0});
        exp_cpu.push_back(12'o1234);
        drive(4'b0001, 12'o0200, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0);
        @(negedge clk);
        check("t1_idle_mem_req", 32'(mem_req), 0);
        check("t1_idle_busy", 32'(busy), 0);
        @(negedge clk);
        check("t1_req_mem_req", 32'(mem_req), 1);
        check("t1_req_busy", 32'(busy), 1);
        check("t1_req_ready", 32'(cpu_mem_ready), 0);
        @(negedge clk);
        check("t1_resp_ready", 32'(cpu_mem_ready), 1);
        check("t1_resp_mem_req", 32'(mem_req), 0);
        check("t1_brk_ready", 32'(brk_mem_ready), 0);
        check("t1_brk_rdata", 32'(brk_read_data), 0);
        @(negedge clk);
        check("t1_after_ready", 32'(cpu_mem_ready), 0);
        check("t1_after_busy", 32'(busy), 0);
        cycles(3);
        check("t1_rdata_hold", 32'(cpu_read_data), 'o1234);

        // 2a: simultaneous strobes, data-break priority
        exp_mem.push_back('{12'o0100, 12'o0000, 1'b0});
        exp_mem.push_back('{12'o0300, 12'o0000, 1'b0});
        exp_brk.push_back(12'o0777);
        exp_cpu.push_back(12'o4321);
        drive(4'b0011, 12'o0300, 12'o0000, 1'b0, 12'o0100, 12'o0000, 1'b0);
        cycles(10);
        check("t2_grant_brk_last_cpu", 32'(grant_brk), 0);

        // 2b: round-robin instance, pointer alternates ownership
        exp_rr.push_back(12'o0100);
        exp_rr.push_back(12'o0300);
        drive(4'b1100, 12'o0300, 12'o0000, 1'b0, 12'o0100, 12'o0000, 1'b0);
        cycles(10);
        exp_rr.push_back(12'o0110);
        drive(4'b1000, 12'o0000, 12'o0000, 1'b0, 12'o0110, 12'o0000, 1'b0);
        cycles(6);
        exp_rr.push_back(12'o0310);
        exp_rr.push_back(12'o0120);
        drive(4'b1100, 12'o0310, 12'o0000, 1'b0, 12'o0120, 12'o0000, 1'b0);
        cycles(10);
        check("t2_rr_cpu_pulses", 32'(rr_cpu_pulses), 2);
        check("t2_rr_brk_pulses", 32'(rr_brk_pulses), 3);
        check("t2_rr_cpu_rdata", 32'(rr_cpu_read_data), 'o0310);
        check("t2_rr_brk_rdata", 32'(rr_brk_read_data), 'o0120);
        check("t2_rr_grant_brk", 32'(rr_grant_brk), 1);
        check("t2_rr_status", 32'({rr_busy, rr_overrun, rr_timeout}), 0);

        // 3: data-break write with two wait states
        ws = 2;
        exp_mem.push_back('{12'o0010, 12'o7777, 1'b1});
        exp_brk.push_back(12'o7777);
        drive(4'b0010, 12'o0000, 12'o0000, 1'b0, 12'o0010, 12'o7777, 1'b1);
        cycles(10);
        check("t3_grant_brk", 32'(grant_brk), 1);
        check("t3_brk_rdata", 32'(brk_read_data), 'o7777);
        brk_write_enable = 1'b0;
        ws = 0;

        // 4: overrun on back-to-back strobes, clear, then strobe in the ready cycle
        exp_mem.push_back('{12'o0200, 12'o0000, 1'b0});
        exp_cpu.push_back(12'o1234);
        drive(4'b0001, 12'o0200, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0);
        drive(4'b0001, 12'o0300, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0);
        @(negedge clk);
        check("t4_overrun_set", 32'(overrun), 1);
        cycles(6);
        pulse_clr();
        @(negedge clk);
        check("t4_overrun_clr", 32'(overrun), 0);
        exp_mem.push_back('{12'o0200, 12'o0000, 1'b0});
        exp_mem.push_back('{12'o0300, 12'o0000, 1'b0});
        exp_cpu.push_back(12'o1234);
        exp_cpu.push_back(12'o4321);
        drive(4'b0001, 12'o0200, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        check("t4_ready_at_restrobe", 32'(cpu_mem_ready), 1);
        drive(4'b0001, 12'o0300, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0);
        cycles(8);
        check("t4_no_overrun", 32'(overrun), 0);

        // 5: timeout after 8 REQ cycles, late ack ignored
        no_ack = 1'b1;
        exp_mem.push_back('{12'o0200, 12'o0000, 1'b0});
        exp_cpu.push_back(12'o5252);
        drive(4'b0001, 12'o0200, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0);
        req_cycles = 0;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        for (int i = 0; i < 40 && mem_req; i++) begin
            req_cycles++;
            @(negedge clk);
        end
        check("t5_req_cycles", 32'(req_cycles), 8);
        cycles(2);
        check("t5_timeout", 32'(timeout), 1);
        stray_ack = 1'b1;
        cycles(3);
        stray_ack = 1'b0;
        cycles(2);
        check("t5_stray_busy", 32'(busy), 0);
        check("t5_stray_mem_req", 32'(mem_req), 0);
        check("t5_stray_rdata", 32'(cpu_read_data), 'o5252);
        check("t5_timeout_hold", 32'(timeout), 1);
        pulse_clr();
        @(negedge clk);
        check("t5_timeout_clr", 32'(timeout), 0);
        no_ack = 1'b0;

        // 6: asynchronous reset in the middle of a five-wait-state request
        ws = 5;
        exp_mem.push_back('{12'o0300, 12'o0000, 1'b0});
        drive(4'b0001, 12'o0300, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0);
        drive(4'b0001, 12'o0300, 12'o0000, 1'b0, 12'o0000, 12'o0000, 1'b0);
        cycles(2);
        check("t6_pre_mem_req", 32'(mem_req), 1);
        check("t6_pre_overrun", 32'(overrun), 1);
        #2 nrst = 1'b0;
        #1;
        check("t6_rst_mem_req", 32'(mem_req), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_overrun", 32'(overrun), 0);
        check("t6_rst_cpu_rdata", 32'(cpu_read_data), 0);
        exp_cpu.delete();
        cycles(2);
        nrst = 1'b1;
        cycles(10);
        check("t6_no_ready_after_rst", 32'(cpu_mem_ready), 0);
        ws = 0;
        exp_mem.push_back('{12'o0100, 12'o0000, 1'b0});
        exp_brk.push_back(12'o0777);
        drive(4'b0010, 12'o0000, 12'o0000, 1'b0, 12'o0100, 12'o0000, 1'b0);
        cycles(8);
        check("t6_brk_rdata", 32'(brk_read_data), 'o0777);

        // Every expected transaction must have been observed
        check("left_exp_mem", 32'(exp_mem.size()), 0);
        check("left_exp_cpu", 32'(exp_cpu.size()), 0);
        check("left_exp_brk", 32'(exp_brk.size()), 0);
        check("left_exp_rr", 32'(exp_rr.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pdp8_mem_arbiter.md
Name: pdp8_mem_arbiter

Overview:
Shares the single PDP-8 main-memory port between the CPU and a data-break (DMA) requester. Each requester uses the CPU memory handshake: a one-cycle load strobe with address, write data and write enable, answered by a one-cycle ready pulse with read data. The block serialises transactions onto a req/ack memory port and adds timeout and overrun status. It sits between the CPU core, the data-break channel and the memory model/RAM wrapper.

Parameters:
BRK_PRIORITY, 1, 1 = data-break always wins simultaneous requests; 0 = round-robin between the two ports.
TIMEOUT, 16, maximum number of cycles mem_req stays high waiting for mem_ack; 0 disables the timeout.
TMO_DATA, 12'o0000, read data returned to the requester on a timed-out transaction.

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
cpu_address  in  12  CPU word address
cpu_write_data  in  12  CPU write data
cpu_write_enable  in  1  1 = write transaction
cpu_mem_load  in  1  one-cycle transaction strobe
cpu_read_data  out  12  registered read data; holds its value between transactions
cpu_mem_ready  out  1  one-cycle completion pulse
brk_address, brk_write_data, brk_write_enable, brk_mem_load  in  12/12/1/1  data-break equivalents of the CPU inputs
brk_read_data  out  12  data-break read data
brk_mem_ready  out  1  data-break completion pulse
mem_address  out  12  memory address
mem_write_data  out  12  memory write data
mem_write_enable  out  1  memory write enable
mem_req  out  1  held high until mem_ack is sampled or timeout
mem_read_data  in  12  valid when mem_ack is high
mem_ack  in  1  memory completion
clr_status  in  1  clears sticky flags
busy  out  1  state != IDLE
grant_brk  out  1  current or most recent owner is the data-break port
overrun  out  1  sticky: a strobe arrived while that port already had a request outstanding
timeout  out  1  sticky: a transaction timed out

Behaviour:
- Reset (asynchronous): all outputs 0, both pending bits clear, state IDLE, round-robin pointer set to CPU-last. Reset mid-transaction drops mem_req immediately; no ready pulse is issued.
- Capture: a strobe on a port with no outstanding request latches address, data and write enable, and sets pending. A port is outstanding from the capture edge until the edge that ends its ready pulse.
  - A strobe in the same cycle as that port's own ready pulse is accepted as a new request.
  - Any other strobe while outstanding is ignored and sets overrun.
- States:
  - IDLE: if any pending, grant one and go to REQ.
    - BRK_PRIORITY=1: brk wins.
    - BRK_PRIORITY=0: the port not granted last wins; a lone pending port always wins.
  - REQ: mem_req=1; mem_address, mem_write_data and mem_write_enable come from the granted port's latch and are stable throughout.
    - mem_ack sampled high: capture mem_read_data, go to RESP.
    - TIMEOUT!=0 and the cycle count in REQ reaches TIMEOUT without ack: capture TMO_DATA, set timeout, go to RESP.
  - RESP: mem_req=0; the owner's read_data is loaded and its mem_ready is high for exactly one cycle; its pending clears; go to IDLE.
- Write transactions: read_data is loaded with the written data; the ready pulse is identical to a read.
- Latency: with the strobe sampled at edge E0 and ack in the first REQ cycle, mem_req is high over E1..E2 and ready is high over E2..E3. Minimum issue-to-issue spacing is 3 cycles.
- mem_ack while mem_req is low (including a late ack after timeout) is ignored.
- Status flags: clr_status clears overrun and timeout; a same-cycle set takes priority over clear. grant_brk updates on the grant edge.
- With BRK_PRIORITY=1 a continuously strobing brk port may starve the CPU; this is intended, matching data-break semantics.

Decomposition:
- Package pdp8_mem_pkg:
  - word_t (logic [11:0])
  - arb_state_t enum {IDLE, REQ, RESP}
  - port_t enum {PORT_CPU, PORT_BRK}
  - TMO counter width constant
- Sub-module pdp8_mem_req_latch: per-port capture, pending and overrun detection. Instantiated twice.

Test Plan:
1. CPU read 12'o0200, memory acks in the first REQ cycle with 12'o1234 -> cpu_mem_ready one cycle at E2, cpu_read_data=12'o1234, brk outputs idle.
2. Same-cycle strobes with cpu addr 12'o0300 and brk addr 12'o0100:
   - BRK_PRIORITY=1: brk is served first, then cpu.
   - BRK_PRIORITY=0, repeated twice: the grant order alternates.
3. brk write of 12'o7777 to 12'o0010 -> mem_write_enable=1 and mem_write_data=12'o7777 for the whole REQ phase; brk_mem_ready pulses; brk_read_data=12'o7777.
4. CPU strobes on two consecutive cycles -> exactly one memory transaction and overrun=1; clr_status -> overrun=0; a strobe during the ready cycle is accepted.
5. TIMEOUT=8, never ack -> mem_req high for 8 cycles, cpu_mem_ready with cpu_read_data=TMO_DATA, timeout=1; a later stray mem_ack changes nothing.
6. Assert nrst during REQ with a 5-wait-state memory -> mem_req, busy and flags drop to 0 asynchronously; no ready after reset release; a new request then completes normally.
